// File: rtl/uart1_rx_if.sv
// UART1 receive-side signal bundle: serial line in, received byte and status out.
interface uart1_rx_if;
   logic       serial_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       framing_error;
   logic       busy;

   // Driver of the line / consumer of the received byte
   modport master (
      output serial_in,
      input  rx_data,
      input  rx_valid,
      input  framing_error,
      input  busy
   );

   // The receiver itself
   modport slave (
      input  serial_in,
      output rx_data,
      output rx_valid,
      output framing_error,
      output busy
   );
endinterface

// File: rtl/uart1_rx.sv
// UART1 8N1 serial receiver: start-bit qualification at mid-bit, LSB-first
// data capture, stop-bit check with framing-error reporting.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | line high, waiting for a low level on the synchronized input
// START | counting to mid-start-bit; a high sample there is a glitch
// DATA  | sampling 8 data bits, one every CLKS_PER_BIT cycles
// STOP  | sampling the stop bit at its middle; 1 = good frame, 0 = error
// BREAK | stop bit was low; wait for the line to return high
module uart1_rx #(
   parameter int CLKS_PER_BIT = 16,   // >= 4 and even
   parameter int CNT_W        = 8     // 2**CNT_W > CLKS_PER_BIT
) (
   input  logic  clk,
   input  logic  rst,                 // asynchronous, active low
   uart1_rx_if.slave rx
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic       sync1_q, sync2_q;
   logic       s_in;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             framing_error_q, framing_error_d;
   logic             busy_q, busy_d;

   // Two-flop synchronizer; preset to the idle line level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx.serial_in;
         sync2_q <= sync1_q;
      end
   end

   assign s_in = sync2_q;

   // Next-state and output computation for the receive FSM
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      bit_idx_d       = bit_idx_q;
      shift_d         = shift_q;
      rx_data_d       = rx_data_q;
      rx_valid_d      = 1'b0;
      framing_error_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!s_in) state_d = START;
         end

         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               state_d   = s_in ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = s_in;
               if (bit_idx_q == 3'd7) state_d = STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               // Leaving STOP at mid-stop-bit lets a back-to-back start edge be caught
               if (s_in) begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  framing_error_d = 1'b1;
                  state_d         = BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         BREAK: begin
            cnt_d = '0;
            if (s_in) state_d = IDLE;
         end

         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // FSM state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         bit_idx_q       <= 3'd0;
         shift_q         <= 8'h00;
         rx_data_q       <= 8'h00;
         rx_valid_q      <= 1'b0;
         framing_error_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         bit_idx_q       <= bit_idx_d;
         shift_q         <= shift_d;
         rx_data_q       <= rx_data_d;
         rx_valid_q      <= rx_valid_d;
         framing_error_q <= framing_error_d;
         busy_q          <= busy_d;
      end
   end

   assign rx.rx_data       = rx_data_q;
   assign rx.rx_valid      = rx_valid_q;
   assign rx.framing_error = framing_error_q;
   assign rx.busy          = busy_q;

endmodule

// File: tb/tb_uart1_rx.sv
// Directed bench for uart1_rx at 16 clk/bit.
module tb_uart1_rx;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   uart1_rx_if bus();

   uart1_rx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .rx  (bus.slave)
   );

   always #5 clk = ~clk;

   int cyc        = 0;
   int valid_cnt  = 0;
   int fe_cnt     = 0;
   int busy_cnt   = 0;
   int both_cnt   = 0;
   int valid_cyc [$];
   int vectors    = 0;
   int errs       = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1) begin
         valid_cnt++;
         valid_cyc.push_back(cyc);
      end
      if (bus.framing_error === 1'b1) fe_cnt++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.rx_valid === 1'b1 && bus.framing_error === 1'b1) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.serial_in = b;
      cycles(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   int t0, t1, v0, f0, b0, d;

   initial begin
      bus.serial_in = 1'b1;
      rst = 1'b0;
      #12;
      check("reset_rx_data", {24'h0, bus.rx_data}, 32'h00);
      check("reset_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
      check("reset_fe", {31'h0, bus.framing_error}, 32'h0);
      check("reset_busy", {31'h0, bus.busy}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Idle line for 1000 cycles
      cycles(1000);
      check("idle_valid_cnt", valid_cnt, 0);
      check("idle_fe_cnt", fe_cnt, 0);
      check("idle_busy_cnt", busy_cnt, 0);

      // Single frame 0xA5
      t0 = cyc;
      send_frame(8'hA5, 1'b1);
      cycles(4);
      check("a5_valid_cnt", valid_cnt, 1);
      check("a5_rx_data", {24'h0, bus.rx_data}, 32'hA5);
      check("a5_fe_cnt", fe_cnt, 0);
      d = valid_cyc[0] - t0;
      check("a5_latency_154pm1", {31'h0, (d >= 153 && d <= 155)}, 32'h1);
      check("a5_busy_cleared", {31'h0, bus.busy}, 32'h0);
      cycles(20);

      // Back-to-back 0x00 then 0xFF
      send_frame(8'h00, 1'b1);
      check("b2b_first_data", {24'h0, bus.rx_data}, 32'h00);
      send_frame(8'hFF, 1'b1);
      cycles(4);
      check("b2b_valid_cnt", valid_cnt, 3);
      check("b2b_second_data", {24'h0, bus.rx_data}, 32'hFF);
      check("b2b_spacing", valid_cyc[2] - valid_cyc[1], 160);
      cycles(20);

      // Glitch: 4 clk low
      t0 = cyc;
      bus.serial_in = 1'b0;
      cycles(4);
      bus.serial_in = 1'b1;
      cycles(3);
      check("glitch_busy_mid", {31'h0, bus.busy}, 32'h1);
      cycles(12);
      check("glitch_busy_clear", {31'h0, bus.busy}, 32'h0);
      cycles(200);
      check("glitch_valid_cnt", valid_cnt, 3);
      check("glitch_fe_cnt", fe_cnt, 0);

      // Framing error on 0x3C, then hold low 40 clk
      send_frame(8'h3C, 1'b0);
      cycles(40);
      check("fe_pulse_cnt", fe_cnt, 1);
      check("fe_busy_held", {31'h0, bus.busy}, 32'h1);
      check("fe_rx_data_kept", {24'h0, bus.rx_data}, 32'hFF);
      check("fe_no_valid", valid_cnt, 3);
      bus.serial_in = 1'b1;
      cycles(6);
      check("fe_busy_released", {31'h0, bus.busy}, 32'h0);
      cycles(20);
      send_frame(8'h81, 1'b1);
      cycles(4);
      check("after_fe_valid_cnt", valid_cnt, 4);
      check("after_fe_data", {24'h0, bus.rx_data}, 32'h81);
      check("after_fe_fe_cnt", fe_cnt, 1);
      cycles(20);

      // Reset during data bit 4 of 0xC3
      v0 = valid_cnt; f0 = fe_cnt;
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      bus.serial_in = 1'b0;
      cycles(8);
      check("midrst_busy_before", {31'h0, bus.busy}, 32'h1);
      rst = 1'b0;
      #1;
      check("midrst_busy_async", {31'h0, bus.busy}, 32'h0);
      check("midrst_rx_data", {24'h0, bus.rx_data}, 32'h00);
      bus.serial_in = 1'b1;
      cycles(5);
      rst = 1'b1;
      cycles(300);
      check("midrst_no_valid", valid_cnt, v0);
      check("midrst_no_fe", fe_cnt, f0);
      check("midrst_data_zero", {24'h0, bus.rx_data}, 32'h00);
      send_frame(8'h5A, 1'b1);
      cycles(4);
      check("midrst_5a_valid", valid_cnt, v0 + 1);
      check("midrst_5a_data", {24'h0, bus.rx_data}, 32'h5A);
      cycles(20);

      check("exclusive_pulses", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
